// File: rtl/tt_uart_bridge.sv
// Host command bridge: UART byte commands drive ui_in / project reset and read back uo_out.
module tt_uart_bridge #(
   parameter int unsigned CLKS_PER_BIT     = 868,
   parameter int unsigned RST_PULSE_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       uart_rx,
   output logic       uart_tx,
   output logic [7:0] ui_in,
   input  logic [7:0] uo_out,
   output logic       proj_rst_n,
   output logic       busy
);

   localparam int unsigned CNT_W          = $clog2(CLKS_PER_BIT);
   localparam int unsigned TIMEOUT_CYCLES = 160 * CLKS_PER_BIT;
   localparam int unsigned TO_W           = $clog2(TIMEOUT_CYCLES);
   localparam int unsigned RP_W           = (RST_PULSE_CYCLES > 1) ? $clog2(RST_PULSE_CYCLES) : 1;

   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [RP_W-1:0]  RP_LAST   = RP_W'(RST_PULSE_CYCLES - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   localparam logic [2:0] C_IDLE     = 3'd0;
   localparam logic [2:0] C_GET_ARG  = 3'd1;
   localparam logic [2:0] C_RSTPULSE = 3'd2;
   localparam logic [2:0] C_SEND     = 3'd3;
   localparam logic [2:0] C_WAIT_TX  = 3'd4;

   // s1/s2 form the synchronizer, s3 holds the previous synchronized level for edge detect
   logic             rx_s1_q, rx_s2_q, rx_s3_q;
   logic [1:0]       rx_state_q, rx_state_d;
   logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]       rx_idx_q, rx_idx_d;
   logic [7:0]       rx_shift_q, rx_shift_d;
   logic             rx_valid_q, rx_valid_d;

   logic [1:0]       tx_state_q, tx_state_d;
   logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
   logic [2:0]       tx_idx_q, tx_idx_d;
   logic [7:0]       tx_shift_q, tx_shift_d;
   logic             uart_tx_q, uart_tx_d;

   logic [2:0]       cmd_state_q, cmd_state_d;
   logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
   logic [RP_W-1:0]  rp_cnt_q, rp_cnt_d;
   logic [7:0]       tx_byte_q, tx_byte_d;
   logic [7:0]       ui_in_q, ui_in_d;
   logic             proj_rst_n_q, proj_rst_n_d;
   logic             busy_q, busy_d;

   logic             tx_load_c;
   logic             tx_done_c;

   assign tx_load_c = (cmd_state_q == C_SEND);
   assign tx_done_c = (tx_state_q == S_STOP) && (tx_cnt_q == BIT_LAST);

   // State registers for all three FSMs and the outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_s1_q      <= 1'b1;
         rx_s2_q      <= 1'b1;
         rx_s3_q      <= 1'b1;
         rx_state_q   <= S_IDLE;
         rx_cnt_q     <= '0;
         rx_idx_q     <= '0;
         rx_shift_q   <= '0;
         rx_valid_q   <= 1'b0;
         tx_state_q   <= S_IDLE;
         tx_cnt_q     <= '0;
         tx_idx_q     <= '0;
         tx_shift_q   <= '0;
         uart_tx_q    <= 1'b1;
         cmd_state_q  <= C_IDLE;
         to_cnt_q     <= '0;
         rp_cnt_q     <= '0;
         tx_byte_q    <= '0;
         ui_in_q      <= '0;
         proj_rst_n_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         rx_s1_q      <= uart_rx;
         rx_s2_q      <= rx_s1_q;
         rx_s3_q      <= rx_s2_q;
         rx_state_q   <= rx_state_d;
         rx_cnt_q     <= rx_cnt_d;
         rx_idx_q     <= rx_idx_d;
         rx_shift_q   <= rx_shift_d;
         rx_valid_q   <= rx_valid_d;
         tx_state_q   <= tx_state_d;
         tx_cnt_q     <= tx_cnt_d;
         tx_idx_q     <= tx_idx_d;
         tx_shift_q   <= tx_shift_d;
         uart_tx_q    <= uart_tx_d;
         cmd_state_q  <= cmd_state_d;
         to_cnt_q     <= to_cnt_d;
         rp_cnt_q     <= rp_cnt_d;
         tx_byte_q    <= tx_byte_d;
         ui_in_q      <= ui_in_d;
         proj_rst_n_q <= proj_rst_n_d;
         busy_q       <= busy_d;
      end
   end

   // RX: start-edge detect, mid-start glitch check, LSB-first sampling, stop-bit validation
   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_idx_d   = rx_idx_q;
      rx_shift_d = rx_shift_q;
      rx_valid_d = 1'b0;
      case (rx_state_q)
         S_IDLE: begin
            if (rx_s3_q && !rx_s2_q) begin
               rx_state_d = S_START;
               rx_cnt_d   = '0;
            end
         end
         S_START: begin
            if (rx_cnt_q == HALF_LAST) begin
               rx_cnt_d   = '0;
               rx_idx_d   = '0;
               rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
            end else begin
               rx_cnt_d = rx_cnt_q + CNT_W'(1);
            end
         end
         S_DATA: begin
            if (rx_cnt_q == BIT_LAST) begin
               rx_cnt_d   = '0;
               rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
               if (rx_idx_q == 3'd7) begin
                  rx_state_d = S_STOP;
               end else begin
                  rx_idx_d = rx_idx_q + 3'd1;
               end
            end else begin
               rx_cnt_d = rx_cnt_q + CNT_W'(1);
            end
         end
         S_STOP: begin
            if (rx_cnt_q == BIT_LAST) begin
               rx_cnt_d   = '0;
               rx_state_d = S_IDLE;
               rx_valid_d = rx_s2_q;
            end else begin
               rx_cnt_d = rx_cnt_q + CNT_W'(1);
            end
         end
         default: rx_state_d = S_IDLE;
      endcase
   end

   // TX: start bit, 8 data bits LSB-first, stop bit; line value is registered
   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_idx_d   = tx_idx_q;
      tx_shift_d = tx_shift_q;
      uart_tx_d  = uart_tx_q;
      case (tx_state_q)
         S_IDLE: begin
            uart_tx_d = 1'b1;
            if (tx_load_c) begin
               tx_shift_d = tx_byte_q;
               tx_cnt_d   = '0;
               tx_state_d = S_START;
               uart_tx_d  = 1'b0;
            end
         end
         S_START: begin
            if (tx_cnt_q == BIT_LAST) begin
               tx_cnt_d   = '0;
               tx_idx_d   = '0;
               tx_state_d = S_DATA;
               uart_tx_d  = tx_shift_q[0];
            end else begin
               tx_cnt_d = tx_cnt_q + CNT_W'(1);
            end
         end
         S_DATA: begin
            if (tx_cnt_q == BIT_LAST) begin
               tx_cnt_d = '0;
               if (tx_idx_q == 3'd7) begin
                  tx_state_d = S_STOP;
                  uart_tx_d  = 1'b1;
               end else begin
                  tx_idx_d   = tx_idx_q + 3'd1;
                  tx_shift_d = {1'b0, tx_shift_q[7:1]};
                  uart_tx_d  = tx_shift_q[1];
               end
            end else begin
               tx_cnt_d = tx_cnt_q + CNT_W'(1);
            end
         end
         S_STOP: begin
            if (tx_done_c) begin
               tx_cnt_d   = '0;
               tx_state_d = S_IDLE;
            end else begin
               tx_cnt_d = tx_cnt_q + CNT_W'(1);
            end
         end
         default: tx_state_d = S_IDLE;
      endcase
   end

   // Command FSM: decode host bytes, drive ui_in / project reset, queue the reply byte
   always_comb begin
      cmd_state_d = cmd_state_q;
      to_cnt_d    = to_cnt_q;
      rp_cnt_d    = rp_cnt_q;
      tx_byte_d   = tx_byte_q;
      ui_in_d     = ui_in_q;
      case (cmd_state_q)
         C_IDLE: begin
            if (rx_valid_q) begin
               case (rx_shift_q)
                  8'h57: begin
                     cmd_state_d = C_GET_ARG;
                     to_cnt_d    = '0;
                  end
                  8'h52: begin
                     tx_byte_d   = uo_out;
                     cmd_state_d = C_SEND;
                  end
                  8'h58: begin
                     cmd_state_d = C_RSTPULSE;
                     rp_cnt_d    = '0;
                  end
                  default: begin
                     tx_byte_d   = 8'h3F;
                     cmd_state_d = C_SEND;
                  end
               endcase
            end
         end
         C_GET_ARG: begin
            if (rx_valid_q) begin
               ui_in_d     = rx_shift_q;
               tx_byte_d   = rx_shift_q;
               cmd_state_d = C_SEND;
            end else if (to_cnt_q == TO_LAST) begin
               cmd_state_d = C_IDLE;
            end else begin
               to_cnt_d = to_cnt_q + TO_W'(1);
            end
         end
         C_RSTPULSE: begin
            if (rp_cnt_q == RP_LAST) begin
               tx_byte_d   = 8'h58;
               cmd_state_d = C_SEND;
            end else begin
               rp_cnt_d = rp_cnt_q + RP_W'(1);
            end
         end
         C_SEND:    cmd_state_d = C_WAIT_TX;
         C_WAIT_TX: if (tx_done_c) cmd_state_d = C_IDLE;
         default:   cmd_state_d = C_IDLE;
      endcase
      busy_d       = (cmd_state_d != C_IDLE);
      proj_rst_n_d = (cmd_state_d != C_RSTPULSE);
   end

   assign uart_tx    = uart_tx_q;
   assign ui_in      = ui_in_q;
   assign proj_rst_n = proj_rst_n_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_tt_uart_bridge.sv
// Directed + randomized host-command bench for tt_uart_bridge with a byte-level reply model.
module tb_tt_uart_bridge;

   localparam int unsigned CPB = 8;
   localparam int unsigned RPC = 16;
   localparam logic [7:0] CMD_W = 8'h57;
   localparam logic [7:0] CMD_R = 8'h52;
   localparam logic [7:0] CMD_X = 8'h58;
   localparam logic [7:0] NAK   = 8'h3F;

   logic       clk, rst_n, uart_rx, uart_tx, proj_rst_n, busy;
   logic [7:0] ui_in, uo_out;

   int unsigned vectors;
   int unsigned miscompares;
   logic [7:0]  model_ui;

   tt_uart_bridge #(.CLKS_PER_BIT(CPB), .RST_PULSE_CYCLES(RPC)) dut (
      .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx), .uart_tx(uart_tx),
      .ui_in(ui_in), .uo_out(uo_out), .proj_rst_n(proj_rst_n), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Expected reply to a command, straight from the command table
   function automatic logic [7:0] model_reply(input logic [7:0] cmd, input logic [7:0] arg,
                                              input logic [7:0] uo);
      if (cmd == CMD_W)      return arg;
      else if (cmd == CMD_R) return uo;
      else if (cmd == CMD_X) return 8'h58;
      else                   return NAK;
   endfunction

   task automatic send_frame(input logic [7:0] b, input logic stop_bit);
      uart_rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      uart_rx = stop_bit;
      repeat (CPB) @(negedge clk);
      uart_rx = 1'b1;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic recv_frame(input int unsigned budget, output logic ok, output logic [7:0] b);
      int unsigned n;
      n  = 0;
      ok = 1'b0;
      b  = 8'h00;
      while (uart_tx !== 1'b0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (uart_tx !== 1'b0) return;
      repeat (CPB / 2) @(negedge clk);
      if (uart_tx !== 1'b0) return;
      for (int i = 0; i < 8; i++) begin
         repeat (CPB) @(negedge clk);
         b[i] = uart_tx;
      end
      repeat (CPB) @(negedge clk);
      ok = (uart_tx === 1'b1);
   endtask

   task automatic quiet_window(input int unsigned cycles, output int unsigned lows);
      lows = 0;
      for (int unsigned i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (uart_tx === 1'b0) lows++;
      end
   endtask

   task automatic measure_pulse(output int unsigned width, output int unsigned lat);
      int unsigned n;
      n     = 0;
      width = 0;
      lat   = 0;
      while (proj_rst_n !== 1'b0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (proj_rst_n !== 1'b0) return;
      while (proj_rst_n === 1'b0 && width < 400) begin
         @(negedge clk);
         width++;
      end
      while (uart_tx !== 1'b0 && lat < 50) begin
         @(negedge clk);
         lat++;
      end
   endtask

   // One complete host transaction: command (+ argument), reply capture and side-effect checks
   task automatic txn(input string tag, input logic [7:0] cmd, input logic [7:0] arg,
                      input logic [7:0] uo_val);
      logic        ok, busy_mid;
      logic [7:0]  got, expv;
      int unsigned width, lat, n;
      width    = 0;
      lat      = 0;
      busy_mid = 1'b0;
      uo_out   = uo_val;
      expv     = model_reply(cmd, arg, uo_val);
      fork
         begin
            send_frame(cmd, 1'b1);
            if (cmd == CMD_W) begin
               check({tag, "_busy_after_w"}, 32'(busy), 32'(1));
               check({tag, "_ui_held"}, 32'(ui_in), 32'(model_ui));
               send_frame(arg, 1'b1);
            end
         end
         recv_frame(1000, ok, got);
         begin
            n = 0;
            while (uart_tx !== 1'b0 && n < 1000) begin
               @(negedge clk);
               n++;
            end
            busy_mid = busy;
            if (cmd == CMD_R) uo_out = ~uo_val;
         end
         begin
            if (cmd == CMD_X) measure_pulse(width, lat);
         end
      join
      if (cmd == CMD_W) model_ui = arg;
      check({tag, "_reply_ok"}, 32'(ok), 32'(1));
      check({tag, "_reply"}, 32'(got), 32'(expv));
      check({tag, "_busy_in_tx"}, 32'(busy_mid), 32'(1));
      check({tag, "_ui_in"}, 32'(ui_in), 32'(model_ui));
      repeat (CPB) @(negedge clk);
      check({tag, "_busy_done"}, 32'(busy), 32'(0));
      if (cmd == CMD_X) begin
         check({tag, "_pulse_width"}, 32'(width), 32'(RPC));
         check({tag, "_tx_latency_ok"}, 32'(lat <= 2), 32'(1));
      end
   endtask

   // Linear test sequence
   initial begin
      int unsigned lows, lows2;
      logic [7:0]  rb;
      vectors     = 0;
      miscompares = 0;
      model_ui    = 8'h00;
      rst_n       = 1'b0;
      uart_rx     = 1'b1;
      uo_out      = 8'h00;

      repeat (3) @(negedge clk);
      check("rst_uart_tx", 32'(uart_tx), 32'(1));
      check("rst_ui_in", 32'(ui_in), 32'(0));
      check("rst_proj_rst_n", 32'(proj_rst_n), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("proj_rst_n_release", 32'(proj_rst_n), 32'(1));
      @(negedge clk);

      txn("w_a5", CMD_W, 8'hA5, 8'h00);
      txn("r_3c", CMD_R, 8'h00, 8'h3C);
      txn("x_pulse", CMD_X, 8'h00, 8'h00);
      txn("nak_11", 8'h11, 8'h00, 8'h00);

      // Framing error on a 'W': no reply, and the next byte is a fresh command
      send_frame(CMD_W, 1'b0);
      quiet_window(20 * CPB, lows);
      check("frame_err_quiet", 32'(lows), 32'(0));
      check("frame_err_busy", 32'(busy), 32'(0));
      txn("after_frame_err", 8'h11, 8'h00, 8'h00);

      // Short low glitch must not start a frame
      uart_rx = 1'b0;
      repeat (2) @(negedge clk);
      uart_rx = 1'b1;
      quiet_window(20 * CPB, lows);
      check("glitch_quiet", 32'(lows), 32'(0));
      check("glitch_busy", 32'(busy), 32'(0));
      txn("after_glitch", 8'h11, 8'h00, 8'h00);

      // Randomized command mix
      for (int i = 0; i < 8; i++) begin
         case ($urandom_range(0, 3))
            0: txn("rand_w", CMD_W, 8'($urandom_range(0, 255)), 8'h00);
            1: txn("rand_r", CMD_R, 8'h00, 8'($urandom_range(0, 255)));
            2: txn("rand_x", CMD_X, 8'h00, 8'h00);
            default: begin
               rb = 8'($urandom_range(0, 255));
               while (rb == CMD_W || rb == CMD_R || rb == CMD_X) rb = 8'($urandom_range(0, 255));
               txn("rand_other", rb, 8'h00, 8'h00);
            end
         endcase
      end

      // 'W' with no argument: busy for ~1280 clocks, then silent return to idle
      send_frame(CMD_W, 1'b1);
      quiet_window(1260, lows);
      check("timeout_busy_before", 32'(busy), 32'(1));
      quiet_window(20, lows2);
      check("timeout_busy_after", 32'(busy), 32'(0));
      check("timeout_quiet", 32'(lows + lows2), 32'(0));
      check("timeout_ui_in", 32'(ui_in), 32'(model_ui));
      txn("after_timeout", 8'h11, 8'h00, 8'h00);

      // Asynchronous reset in the middle of an 'R' reply
      txn("w_5a", CMD_W, 8'h5A, 8'h00);
      uo_out = 8'h00;
      send_frame(CMD_R, 1'b1);
      repeat (2 * CPB) @(negedge clk);
      check("midtx_line_low", 32'(uart_tx), 32'(0));
      check("midtx_busy", 32'(busy), 32'(1));
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_uart_tx", 32'(uart_tx), 32'(1));
      check("async_rst_ui_in", 32'(ui_in), 32'(0));
      check("async_rst_proj_rst_n", 32'(proj_rst_n), 32'(0));
      check("async_rst_busy", 32'(busy), 32'(0));
      model_ui = 8'h00;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      txn("after_reset", 8'h11, 8'h00, 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/tt_uart_bridge.md
# tt_uart_bridge

Host-side command bridge for the Arty A7 board build. It sits directly upstream of the Tiny Tapeout board wrapper: it receives byte commands from the USB-UART, drives the project's dedicated inputs and reset, and returns samples of the project's dedicated outputs to the host. This lets a PC exercise the project on the FPGA without pushbuttons or switches.

## Interface

- CLKS_PER_BIT, default 868: clock cycles per UART bit (115200 baud at 100 MHz); must be ≥ 4.
- RST_PULSE_CYCLES, default 16: length of the project-reset pulse, in clocks; must be ≥ 1.

Ports:

- clk  in  1  board clock; every flop is on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- uart_rx  in  1  serial in, 8N1, idle high; asynchronous to clk.
- uart_tx  out  1  serial out, 8N1, idle high.
- ui_in  out  8  drives the wrapper's ui_in.
- uo_out  in  8  from the wrapper's uo_out.
- proj_rst_n  out  1  drives the wrapper's rst_n.
- busy  out  1  high whenever the command FSM is not IDLE.

## Operation

- Reset values:
  - uart_tx = 1, ui_in = 0x00, proj_rst_n = 0, busy = 0.
  - All FSMs are in IDLE.
- proj_rst_n goes to 1 on the first clk edge after rst_n deasserts, except while a reset pulse is active.
- RX path:
  - uart_rx passes through a 2-flop synchronizer.
  - A falling edge in IDLE starts a frame.
  - The start bit is re-checked at CLKS_PER_BIT/2; if it is high there, the frame is aborted as a glitch.
  - 8 data bits are sampled LSB-first, one every CLKS_PER_BIT from mid-start.
  - Stop bit sampled 0: framing error, byte discarded, no rx_valid.
  - Stop bit sampled 1: a 1-cycle internal rx_valid pulse is issued with the byte.
- TX path:
  - Accepts a byte only when idle.
  - Sends start bit, 8 data bits LSB-first, stop bit; each bit lasts CLKS_PER_BIT clocks.
  - Raises an internal tx_done when the stop bit completes.
- Command FSM states: IDLE, GET_ARG, RSTPULSE, SEND, WAIT_TX.
  - IDLE, rx 0x57 ('W'): go to GET_ARG.
  - IDLE, rx 0x52 ('R'): capture uo_out that cycle, then SEND it.
  - IDLE, rx 0x58 ('X'): go to RSTPULSE.
  - IDLE, any other byte: SEND 0x3F ('?').
  - GET_ARG, rx byte D: ui_in <= D, then SEND D as an echo.
  - GET_ARG timeout: no byte within 16·10·CLKS_PER_BIT clocks returns to IDLE with no reply and ui_in unchanged.
  - RSTPULSE: proj_rst_n = 0 for exactly RST_PULSE_CYCLES clocks, then SEND 0x58.
  - SEND: load the TX byte, go to WAIT_TX.
  - WAIT_TX: on tx_done, go to IDLE.
- Bytes received while in RSTPULSE, SEND or WAIT_TX are dropped silently. The host must wait for each reply.
- ui_in changes only on a 'W' argument.
- Mid-operation rst_n assertion: everything returns to reset values immediately (asynchronous), including uart_tx = 1 mid-frame.

## Timing

- rx_valid occurs at the stop-bit sample point, (9.5·CLKS_PER_BIT + 2) clocks after the falling start edge on the pin.
- ui_in update: on the clock edge 1 cycle after rx_valid of the 'W' argument.
- 'R' sample point: uo_out is registered on the edge where the FSM decodes rx_valid. The value is not re-sampled later.
- TX start-bit falling edge: no more than 2 clocks after the triggering rx_valid, or after the end of the reset pulse.
- proj_rst_n low window: begins 1 clock after the 'X' rx_valid and lasts exactly RST_PULSE_CYCLES clocks.
- busy: rises 1 clock after the first rx_valid of a command; falls on the tx_done clock, or on GET_ARG timeout.
- Back-to-back frames with a 1-bit idle gap are all received.

## Test plan

Simulate with CLKS_PER_BIT = 8.

- Reset, then idle: uart_tx = 1, ui_in = 0x00, busy = 0; proj_rst_n = 0 during reset and 1 one clock after release.
- Send 0x57, then 0xA5: ui_in = 0xA5 one clock after the second rx_valid; TX returns 0xA5; busy falls at tx_done.
- Set uo_out = 0x3C and send 0x52: TX returns 0x3C. Changing uo_out to 0xFF after the decode edge does not alter the reply.
- Send 0x58 with RST_PULSE_CYCLES = 16: proj_rst_n is low for exactly 16 clocks, then TX returns 0x58.
- Send 0x11: TX returns 0x3F. Send a frame with stop bit = 0: no reply, no state change. Send a 2-clock low glitch: no frame.
- Send 0x57 with no argument: timeout after 1280 clocks, no reply, ui_in unchanged. Then assert rst_n mid-TX of an 'R' reply: uart_tx = 1 and ui_in = 0x00 immediately.
